regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Integer register file at the receiving end of the write-back interface.
- Accepts the WB stage's write port (wen/waddr/wdata).
- Provides two combinational read ports to ID, with same-cycle write-through bypass.
- Keeps a per-register pending-write scoreboard so ID can detect RAW hazards.
- A post-reset clear sequencer zeroes the array one entry per cycle before the core is released.

Parameters:
- REG_NUM, 32: number of architectural registers; x0 is hardwired zero.
- DATA_W, 32: register width.
- ADDR_W, 5: register address width; must satisfy 2**ADDR_W == REG_NUM.
- CLEAR_ON_RESET, 1: 1 = run the sequential clear after reset; 0 = enter RUN immediately, array contents undefined.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- wb_reg_wen  in  1  write enable from WB.
- wb_reg_waddr  in  ADDR_W  write address.
- wb_reg_wdata  in  DATA_W  write data.
- id_rs1_addr  in  ADDR_W  read port 1 address.
- id_rs2_addr  in  ADDR_W  read port 2 address.
- id_rs1_rdata  out  DATA_W  read port 1 data, combinational.
- id_rs2_rdata  out  DATA_W  read port 2 data, combinational.
- id_rd_claim  in  1  an instruction issuing from ID will write id_rd_addr.
- id_rd_addr  in  ADDR_W  destination being claimed.
- id_rs1_busy  out  1  rs1 has an outstanding write not resolvable this cycle.
- id_rs2_busy  out  1  rs2 has an outstanding write not resolvable this cycle.
- sb_flush  in  1  pipeline flush; clears all pending counts.
- sb_overflow  out  1  sticky error: a claim hit a saturated count.
- rf_ready  out  1  clear sequence done; core may issue.

Behaviour:
- Reset: clk and rst are one clock domain; reset is asynchronous and active-high.
  - On reset: state=CLEAR (or RUN if CLEAR_ON_RESET=0), clear_ptr=0, all pending counts=0, sb_overflow=0.
  - rf_ready=0 while in CLEAR.
  - Array contents are not reset asynchronously.
- FSM CLEAR:
  - Each cycle writes 0 to entry clear_ptr, then clear_ptr++.
  - After writing entry REG_NUM-1, transition to RUN. rf_ready=1 from the first RUN cycle, i.e. REG_NUM cycles after rst deasserts.
  - In CLEAR: WB writes and claims are ignored, read data=0, both busy outputs=1.
  - sb_flush has no effect.
- FSM RUN: stays in RUN until rst. Reset mid-operation returns to CLEAR and restarts at ptr 0.
- Write: on the clk edge, if wb_reg_wen && waddr!=0, then array[waddr] <= wdata. Writes to x0 are dropped.
- Read, per port:
  - addr==0 -> 0.
  - else if wen && waddr==addr -> wb_reg_wdata (bypass).
  - else array[addr].
  - No read latency.
- Scoreboard: 2-bit pending count per register; x0 is never tracked.
  - inc = claim && rd_addr!=0.
  - dec = wen && waddr!=0 && cnt[waddr]!=0.
  - Same register inc and dec in the same cycle -> count unchanged.
  - dec at count 0 -> stays 0 (unclaimed write is legal, e.g. after a flush).
  - inc at count 3 -> count stays 3 and sb_overflow is set to 1 (sticky until rst).
- sb_flush: all counts go to 0 on the next edge and has priority over inc/dec in that cycle. An array write in the same cycle still occurs.
- Busy, per port:
  - busy = addr!=0 && (cnt[addr] - (wen && waddr==addr && cnt[addr]!=0)) != 0.
  - A last outstanding write arriving this cycle is bypassed, so it is not busy.
  - Busy ignores a same-cycle claim; ID must not claim and read-check its own rd.
- Both read ports may address the same register; the results must be identical.

Test Plan:
- Reset, CLEAR_ON_RESET=1: assert rst, release; hold wen=1 waddr=5 wdata=0xDEADBEEF during clear -> rf_ready=0 for 32 cycles, busy=1, then rf_ready=1. Reading x5 returns 0, so the write during clear is ignored.
- Write/read/bypass: write x7=0x12345678. Next cycle read rs1=7 -> 0x12345678. Same-cycle write x7=0xA5A5A5A5 with rs2=7 -> rs2_rdata=0xA5A5A5A5 combinationally. Write x0=0xFFFFFFFF -> read x0 = 0.
- Scoreboard: claim x3 twice -> rs1=3 busy. First WB write to x3 -> still busy (count 2→1). Second WB write -> busy=0 in that same cycle, data bypassed. Next cycle count=0.
- Simultaneous claim and write to x9 at count 1 -> count stays 1, busy=1. Claims to x9 taking count to 3, then one more claim -> sb_overflow=1, stays 1 after further writes.
- Flush: claim x4 and x8, then sb_flush=1 with a concurrent claim of x4 and a write x8=0x55 -> all busy=0 next cycle, x8 reads 0x55. A subsequent unclaimed write to x4 leaves count 0.
- Reset mid-run: after RUN with x2=0x1, assert rst asynchronously mid-cycle -> rf_ready drops immediately, busy=1, counts cleared. After 32 cycles x2 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with two combinational bypassed read ports, a per-register
// pending-write scoreboard for RAW hazard detection, and a post-reset clear sequencer.
module regfile_sb #(
  parameter int REG_NUM        = 32,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_wen,
  input  logic [ADDR_W-1:0] wb_reg_waddr,
  input  logic [DATA_W-1:0] wb_reg_wdata,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  output logic [DATA_W-1:0] id_rs1_rdata,
  output logic [DATA_W-1:0] id_rs2_rdata,
  input  logic              id_rd_claim,
  input  logic [ADDR_W-1:0] id_rd_addr,
  output logic              id_rs1_busy,
  output logic              id_rs2_busy,
  input  logic              sb_flush,
  output logic              sb_overflow,
  output logic              rf_ready
);

  localparam logic [0:0]        S_CLEAR  = 1'b0;
  localparam logic [0:0]        S_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clear_ptr;
  logic [1:0]        r_cnt [REG_NUM];
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem [REG_NUM];

  logic              w_run;
  logic              w_wr_hit;
  logic              w_claim;
  logic [REG_NUM-1:0] w_inc_vec;
  logic [REG_NUM-1:0] w_dec_vec;
  logic [1:0]        w_cnt_nxt [REG_NUM];
  logic              w_ovf_set;

  assign w_run    = (r_state == S_RUN);
  assign w_wr_hit = wb_reg_wen && (wb_reg_waddr != '0);
  assign w_claim  = id_rd_claim && (id_rd_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_clear_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clear_ptr <= r_clear_ptr + ADDR_W'(1);
      if (r_clear_ptr == LAST_IDX) begin
        r_state <= S_RUN;
      end
    end
  end

  // Storage has no reset; the clear sequencer owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_clear_ptr] <= '0;
    end else if (w_wr_hit) begin
      r_mem[wb_reg_waddr] <= wb_reg_wdata;
    end
  end

  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      w_inc_vec[i] = w_claim && (id_rd_addr == ADDR_W'(i));
      w_dec_vec[i] = w_wr_hit && (wb_reg_waddr == ADDR_W'(i)) && (r_cnt[i] != 2'd0);
    end
  end

  always_comb begin
    w_ovf_set = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (sb_flush) begin
        w_cnt_nxt[i] = 2'd0;
      end else if (w_inc_vec[i] && !w_dec_vec[i]) begin
        if (r_cnt[i] == 2'd3) begin
          w_ovf_set = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 2'd1;
        end
      end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_cnt[i] <= 2'd0;
      end
      r_overflow <= 1'b0;
    end else if (w_run) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    if (!w_run || (a == '0)) begin
      return '0;
    end
    if (w_wr_hit && (wb_reg_waddr == a)) begin
      return wb_reg_wdata;
    end
    return r_mem[a];
  endfunction

  // A write retiring the last outstanding claim is bypassed, so it does not stall.
  function automatic logic f_busy(input logic [ADDR_W-1:0] a);
    logic w_hit;
    if (!w_run) begin
      return 1'b1;
    end
    if (a == '0) begin
      return 1'b0;
    end
    w_hit = wb_reg_wen && (wb_reg_waddr == a) && (r_cnt[a] != 2'd0);
    return (r_cnt[a] - {1'b0, w_hit}) != 2'd0;
  endfunction

  assign id_rs1_rdata = f_read(id_rs1_addr);
  assign id_rs2_rdata = f_read(id_rs2_addr);
  assign id_rs1_busy  = f_busy(id_rs1_addr);
  assign id_rs2_busy  = f_busy(id_rs2_addr);
  assign sb_overflow  = r_overflow;
  assign rf_ready     = w_run;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes model predictions, monitor compares at negedge.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_wen;
  logic [4:0]  wb_reg_waddr;
  logic [31:0] wb_reg_wdata;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_rdata;
  logic [31:0] id_rs2_rdata;
  logic        id_rd_claim;
  logic [4:0]  id_rd_addr;
  logic        id_rs1_busy;
  logic        id_rs2_busy;
  logic        sb_flush;
  logic        sb_overflow;
  logic        rf_ready;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_rdata(id_rs1_rdata), .id_rs2_rdata(id_rs2_rdata),
    .id_rd_claim(id_rd_claim), .id_rd_addr(id_rd_addr),
    .id_rs1_busy(id_rs1_busy), .id_rs2_busy(id_rs2_busy),
    .sb_flush(sb_flush), .sb_overflow(sb_overflow), .rf_ready(rf_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
    logic        ovf;
    logic        rdy;
  } exp_t;

  exp_t q[$];

  // Reference model: register contents, pending counts, sticky overflow, clear cycles left.
  int unsigned m_mem [32];
  int          m_cnt [32];
  bit          m_ovf;
  int          m_clear_left;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 0;
      m_cnt[i] = 0;
    end
    m_ovf = 1'b0;
    m_clear_left = 32;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (m_clear_left > 0 || a == 0) return 32'h0;
    if (wb_reg_wen && wb_reg_waddr == a) return wb_reg_wdata;
    return m_mem[a];
  endfunction

  function automatic logic m_busy(input int a);
    int pend;
    if (m_clear_left > 0) return 1'b1;
    if (a == 0) return 1'b0;
    pend = m_cnt[a];
    if (wb_reg_wen && wb_reg_waddr == a && pend > 0) pend = pend - 1;
    return pend > 0;
  endfunction

  function automatic void model_edge();
    bit inc;
    bit dec;
    int wa;
    int rd;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_clear_left > 0) begin
      m_clear_left = m_clear_left - 1;
      return;
    end
    wa = int'(wb_reg_waddr);
    rd = int'(id_rd_addr);
    if (wb_reg_wen && wa != 0) m_mem[wa] = wb_reg_wdata;
    if (sb_flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      return;
    end
    inc = id_rd_claim && rd != 0;
    dec = wb_reg_wen && wa != 0 && m_cnt[wa] > 0;
    if (inc && dec && rd == wa) return;
    if (dec) m_cnt[wa] = m_cnt[wa] - 1;
    if (inc) begin
      if (m_cnt[rd] == 3) m_ovf = 1'b1;
      else m_cnt[rd] = m_cnt[rd] + 1;
    end
  endfunction

  task automatic drv(input logic we, input int wa, input logic [31:0] wd,
                     input int a1, input int a2, input logic cl, input int rd, input logic fl);
    wb_reg_wen   = we;
    wb_reg_waddr = 5'(wa);
    wb_reg_wdata = wd;
    id_rs1_addr  = 5'(a1);
    id_rs2_addr  = 5'(a2);
    id_rd_claim  = cl;
    id_rd_addr   = 5'(rd);
    sb_flush     = fl;
  endtask

  task automatic cyc();
    exp_t e;
    e.r1  = m_read(int'(id_rs1_addr));
    e.r2  = m_read(int'(id_rs2_addr));
    e.b1  = m_busy(int'(id_rs1_addr));
    e.b2  = m_busy(int'(id_rs2_addr));
    e.ovf = m_ovf;
    e.rdy = (m_clear_left == 0);
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", n, $time, act, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rs1_rdata",  id_rs1_rdata, e.r1);
        chk("rs2_rdata",  id_rs2_rdata, e.r2);
        chk("rs1_busy",   {31'h0, id_rs1_busy}, {31'h0, e.b1});
        chk("rs2_busy",   {31'h0, id_rs2_busy}, {31'h0, e.b2});
        chk("sb_overflow",{31'h0, sb_overflow}, {31'h0, e.ovf});
        chk("rf_ready",   {31'h0, rf_ready},    {31'h0, e.rdy});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we;
    logic        cl;
    logic        fl;
    int          wa;
    int          rd;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    cyc();
    cyc();

    // Clear sequence with a write, claim and flush held that must all be ignored.
    rst = 1'b0;
    drv(1, 5, 32'hDEADBEEF, 5, 5, 1, 6, 1);
    repeat (32) cyc();
    drv(0, 0, 0, 5, 6, 0, 0, 0);
    cyc();

    // Write, read-after-write, same-cycle bypass on both ports, x0 write dropped.
    drv(1, 7, 32'h12345678, 0, 0, 0, 0, 0); cyc();
    drv(0, 0, 0, 7, 0, 0, 0, 0);            cyc();
    drv(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0); cyc();
    drv(1, 0, 32'hFFFFFFFF, 0, 7, 0, 0, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0);            cyc();

    // Two claims on x3, retired one at a time.
    drv(0, 0, 0, 3, 0, 1, 3, 0);            cyc();
    drv(0, 0, 0, 3, 0, 1, 3, 0);            cyc();
    drv(0, 0, 0, 3, 3, 0, 0, 0);            cyc();
    drv(1, 3, 32'h00000031, 3, 0, 0, 0, 0); cyc();
    drv(1, 3, 32'h00000033, 3, 3, 0, 0, 0); cyc();
    drv(0, 0, 0, 3, 3, 0, 0, 0);            cyc();

    // Claim and write on x9 in one cycle, then saturate and overflow.
    drv(0, 0, 0, 0, 0, 1, 9, 0);            cyc();
    drv(1, 9, 32'h99, 9, 0, 1, 9, 0);       cyc();
    drv(0, 0, 0, 9, 0, 1, 9, 0);            cyc();
    drv(0, 0, 0, 9, 0, 1, 9, 0);            cyc();
    drv(0, 0, 0, 9, 0, 1, 9, 0);            cyc();
    drv(1, 9, 32'h9A, 9, 9, 0, 0, 0);       cyc();
    drv(1, 9, 32'h9B, 9, 9, 0, 0, 0);       cyc();
    drv(0, 0, 0, 9, 9, 0, 0, 0);            cyc();

    // Flush beats a concurrent claim; the concurrent write still lands.
    drv(0, 0, 0, 0, 0, 1, 4, 0);            cyc();
    drv(0, 0, 0, 4, 8, 1, 8, 0);            cyc();
    drv(1, 8, 32'h55, 4, 8, 1, 4, 1);       cyc();
    drv(0, 0, 0, 4, 8, 0, 0, 0);            cyc();
    drv(1, 4, 32'h44, 4, 0, 0, 0, 0);       cyc();
    drv(0, 0, 0, 4, 8, 0, 0, 0);            cyc();

    // Randomized traffic with biased addresses so reads, writes and claims collide.
    for (int n = 0; n < 600; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      cl = 1'($urandom_range(0, 2) == 0);
      rd = int'($urandom_range(0, 7));
      fl = 1'($urandom_range(0, 24) == 0);
      if (cl && we && rd == wa && rd != 0 && m_cnt[rd] == 3) cl = 1'b0;
      drv(we, wa, $urandom(), int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31)), cl, rd, fl);
      cyc();
    end

    // Asynchronous reset in the middle of a cycle, then the clear sequence again.
    drv(1, 2, 32'h1, 0, 0, 1, 2, 0);        cyc();
    drv(0, 0, 0, 2, 2, 0, 0, 0);            cyc();
    #2;
    rst = 1'b1;
    model_reset();
    cyc();
    rst = 1'b0;
    repeat (32) cyc();
    drv(0, 0, 0, 2, 9, 0, 0, 0);            cyc();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
